// File: rtl/nios2_pio_pkg.sv
// Shared constants for the edge-capturing PIO input block: register map,
// edge-mode encodings and the per-bit edge detector.
package nios2_pio_pkg;

    localparam int BUS_W  = 32;
    localparam int ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_IRQMASK = 2'd1,
        ADDR_RSVD    = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Compare the current filtered value against its one-cycle-old copy.
    function automatic logic [BUS_W-1:0] edge_detect(input int mode,
                                                      input logic [BUS_W-1:0] cur,
                                                      input logic [BUS_W-1:0] prev);
        case (mode)
            EDGE_RISE: edge_detect = cur & ~prev;
            EDGE_FALL: edge_detect = ~cur & prev;
            default:   edge_detect = cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/nios2_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the PIO input block.
interface nios2_pio_in_edge_if;
    import nios2_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios2_pio_sync_debounce.sv
// One input bit: SYNC_STAGES flip-flop synchronizer followed by an optional
// debounce filter that only accepts a value held for DEBOUNCE_CYCLES clocks.
module nios2_pio_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign dout = synced;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

            logic [CNT_W-1:0] cnt;
            logic             filt;

            // A single bit can only differ from filt in one way, so any change
            // during the count makes synced equal filt again and zeroes cnt.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (synced == filt) begin
                    cnt <= '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt <= synced;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign dout = filt;
        end
    endgenerate

endmodule

// File: rtl/nios2_pio_in_edge.sv
// Avalon-MM PIO input port with per-bit synchronizer/debounce, edge capture
// register (write-1-to-clear), interrupt mask and a registered level irq.
module nios2_pio_in_edge
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    nios2_pio_in_edge_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0] filt_p0;
    logic [WIDTH-1:0] filt_p1;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [BUS_W-1:0] rd_mux;
    logic             wr;
    logic             unused_ok;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios2_pio_sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .dout    (filt_p0[i])
        );
    end

    assign wr        = bus.chipselect & ~bus.write_n;
    assign edges     = WIDTH'(edge_detect(EDGE_MODE, BUS_W'(filt_p0), BUS_W'(filt_p1)));
    assign clr_mask  = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_ok = &{1'b0, bus.writedata};

    // Stage p1: delayed filtered copy, capture/mask registers and irq.
    // A new edge is OR-ed in after the clear so it wins a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_p1 <= '0;
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            filt_p1 <= filt_p0;
            if (wr && bus.address == ADDR_IRQMASK) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            edgecap <= (edgecap & ~clr_mask) | edges;
            irq     <= |(edgecap & irqmask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux = BUS_W'(filt_p0);
            ADDR_IRQMASK: rd_mux = BUS_W'(irqmask);
            ADDR_EDGECAP: rd_mux = BUS_W'(edgecap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// Bench for nios2_pio_in_edge: three instances (rising, debounced, any-edge)
// on a shared bus with per-instance chipselect and a read scoreboard.
module tb_nios2_pio_in_edge;
    import nios2_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  cs;
    logic [7:0]  in0, in1, in2;
    logic [2:0]  irq;
    logic [2:0][31:0] rd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          idx_q[$];

    always #5 clk = ~clk;

    nios2_pio_in_edge_if bus0();
    nios2_pio_in_edge_if bus1();
    nios2_pio_in_edge_if bus2();

    assign bus0.address = address;  assign bus0.write_n = write_n;
    assign bus0.writedata = writedata;  assign bus0.chipselect = cs[0];
    assign bus1.address = address;  assign bus1.write_n = write_n;
    assign bus1.writedata = writedata;  assign bus1.chipselect = cs[1];
    assign bus2.address = address;  assign bus2.write_n = write_n;
    assign bus2.writedata = writedata;  assign bus2.chipselect = cs[2];
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign rd[2] = bus2.readdata;

    nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .DEBOUNCE_CYCLES(0))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq[0]));

    nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .DEBOUNCE_CYCLES(4))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq[1]));

    nios2_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_ANY), .DEBOUNCE_CYCLES(0))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in2), .irq(irq[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int idx, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs        = 3'b000;
        cs[idx]   = 1'b1;
        @(posedge clk);
        #1;
        cs      = 3'b000;
        write_n = 1'b1;
    endtask

    task automatic sb_pop();
        int          idx;
        logic [31:0] exp;
        string       tag;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got no entry expected one");
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            idx = idx_q.pop_front();
            chk(tag, rd[idx], exp);
        end
    endtask

    task automatic read_expect(input int idx, input logic [1:0] a, input logic [31:0] exp,
                               input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        idx_q.push_back(idx);
        address = a;
        write_n = 1'b1;
        cs      = 3'b000;
        cs[idx] = 1'b1;
        @(posedge clk);
        #1;
        cs = 3'b000;
        sb_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cs = 3'b000; write_n = 1'b1; address = 2'd0; writedata = '0;
        in0 = '0; in1 = '0; in2 = '0;
        wait_clk(2);
        chk("rst_rd0", rd[0], 32'h0);
        chk("rst_irq", {29'b0, irq}, 32'h0);
        #3 reset_n = 1'b1;
        wait_clk(1);

        read_expect(0, ADDR_DATA,    32'h0, "rst_data");
        read_expect(0, ADDR_IRQMASK, 32'h0, "rst_mask");
        read_expect(0, ADDR_EDGECAP, 32'h0, "rst_cap");
        read_expect(0, ADDR_RSVD,    32'h0, "rst_rsvd");

        // Data path latency and rising capture of the pattern
        in0 = 8'hA5;
        wait_clk(2);
        read_expect(0, ADDR_DATA,    32'h000000A5, "data_a5");
        read_expect(0, ADDR_EDGECAP, 32'h000000A5, "cap_a5");
        read_expect(0, ADDR_EDGECAP, 32'h000000A5, "cap_noside");
        bus_write(0, ADDR_EDGECAP, 32'hFF);
        read_expect(0, ADDR_EDGECAP, 32'h0, "w1c_all");
        in0 = 8'h00;
        wait_clk(4);
        read_expect(0, ADDR_EDGECAP, 32'h0, "fall_ignored");
        read_expect(0, ADDR_DATA,    32'h0, "data_zero");

        // Rising edge with irq, then clear and irq lag
        bus_write(0, ADDR_IRQMASK, 32'h1);
        read_expect(0, ADDR_IRQMASK, 32'h1, "mask_01");
        in0 = 8'h01;
        wait_clk(4);
        read_expect(0, ADDR_EDGECAP, 32'h1, "rise_cap");
        chk("rise_irq", {31'b0, irq[0]}, 32'h1);
        bus_write(0, ADDR_EDGECAP, 32'h1);
        chk("irq_lag", {31'b0, irq[0]}, 32'h1);
        wait_clk(1);
        chk("irq_clr", {31'b0, irq[0]}, 32'h0);
        read_expect(0, ADDR_EDGECAP, 32'h0, "cap_clr");

        // Clear landing in the same cycle as bit 3's edge
        in0 = 8'h09;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_write(0, ADDR_EDGECAP, 32'hFF);
        read_expect(0, ADDR_EDGECAP, 32'h08, "clr_vs_edge");
        chk("irq_masked", {31'b0, irq[0]}, 32'h0);

        // Ignored writes and truncation
        bus_write(0, ADDR_DATA, 32'hFF);
        bus_write(0, ADDR_RSVD, 32'hFF);
        read_expect(0, ADDR_DATA,    32'h09, "data_ro");
        read_expect(0, ADDR_RSVD,    32'h0,  "rsvd_zero");
        read_expect(0, ADDR_IRQMASK, 32'h1,  "mask_kept");
        bus_write(0, ADDR_IRQMASK, 32'hFFFFFF02);
        read_expect(0, ADDR_IRQMASK, 32'h02, "mask_trunc");

        // Debounce: 3-clock glitch rejected, long hold accepted once
        in1 = 8'h02;
        wait_clk(3);
        in1 = 8'h00;
        wait_clk(10);
        read_expect(1, ADDR_DATA,    32'h0, "deb_glitch_data");
        read_expect(1, ADDR_EDGECAP, 32'h0, "deb_glitch_cap");
        in1 = 8'h02;
        wait_clk(3);
        read_expect(1, ADDR_DATA,    32'h0,  "deb_pending");
        wait_clk(6);
        read_expect(1, ADDR_DATA,    32'h02, "deb_data");
        read_expect(1, ADDR_EDGECAP, 32'h02, "deb_edge");
        chk("deb_irq", {31'b0, irq[1]}, 32'h0);

        // Any-edge mode on bit 7
        in2 = 8'h80;
        wait_clk(4);
        read_expect(2, ADDR_EDGECAP, 32'h80, "any_rise");
        chk("any_irq_a", {31'b0, irq[2]}, 32'h0);
        bus_write(2, ADDR_EDGECAP, 32'h80);
        read_expect(2, ADDR_EDGECAP, 32'h0, "any_clr");
        in2 = 8'h00;
        wait_clk(4);
        read_expect(2, ADDR_EDGECAP, 32'h80, "any_fall");
        chk("any_irq_b", {31'b0, irq[2]}, 32'h0);

        // Reset in the middle of operation
        in0 = 8'h00;
        wait_clk(4);
        in0 = 8'hFF;
        wait_clk(4);
        bus_write(0, ADDR_IRQMASK, 32'hFF);
        wait_clk(1);
        read_expect(0, ADDR_EDGECAP, 32'hFF, "pre_rst_cap");
        chk("pre_rst_irq", {31'b0, irq[0]}, 32'h1);
        in0 = 8'h00;
        reset_n = 1'b0;
        #1;
        chk("rst_async_irq", {31'b0, irq[0]}, 32'h0);
        chk("rst_async_rd",  rd[0], 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        wait_clk(6);
        read_expect(0, ADDR_EDGECAP, 32'h0, "post_rst_cap");
        read_expect(0, ADDR_IRQMASK, 32'h0, "post_rst_mask");
        read_expect(0, ADDR_DATA,    32'h0, "post_rst_data");
        chk("post_rst_irq", {31'b0, irq[0]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_pio_in_edge.md
NIOS2_PIO_IN_EDGE -- requirements
Module: nios2_pio_in_edge

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 8: input port width, legal range 1..32.
- SYNC_STAGES, default 2: synchronizer depth, legal range 2..3.
- EDGE_MODE, default 0: edge type captured; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, default 0: stable cycles required before a filtered bit changes; 0 = bypass.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt.

REQ-003 The block SHALL expose this register map:
- 0 DATA: read-only, filtered input value.
- 1 IRQMASK: read/write, WIDTH bits.
- 2 reserved: reads 0.
- 3 EDGECAP: read, write-1-to-clear.

Function
REQ-004 The block SHALL pass each in_port bit through a SYNC_STAGES flip-flop synchronizer before any other use.
REQ-005 When DEBOUNCE_CYCLES > 0, each filtered bit SHALL take a new synchronized value only after that value has been stable for DEBOUNCE_CYCLES consecutive clocks.
REQ-006 Any change in a bit's synchronized value during the debounce count SHALL restart that bit's counter from zero.
REQ-007 When DEBOUNCE_CYCLES = 0, the filtered value SHALL equal the synchronized value.
REQ-008 The block SHALL keep a one-cycle-delayed copy of the filtered value and detect edges per EDGE_MODE by comparing the two.
REQ-009 A detected edge SHALL set the corresponding EDGECAP bit on the following clock edge, and the bit SHALL remain set until cleared.
REQ-010 A write (chipselect=1, write_n=0) to address 3 SHALL clear every EDGECAP bit whose writedata bit is 1.
REQ-011 If a clear and a new edge hit the same bit in the same cycle, the new edge SHALL win and the bit SHALL stay 1.
REQ-012 A write to address 1 SHALL load IRQMASK from writedata[WIDTH-1:0].
REQ-013 Writes to addresses 0 and 2 SHALL be ignored.
REQ-014 irq SHALL be registered and equal the OR-reduction of (EDGECAP AND IRQMASK), lagging those registers by one clock.
REQ-015 readdata SHALL be updated on every clock with the register selected by address, zero-extended above WIDTH, giving read latency 1.
REQ-016 Reads SHALL have no side effects.
REQ-017 Widths narrower than 32 bits SHALL truncate writedata and zero-fill readdata.

Reset
REQ-018 Asserting reset_n low SHALL asynchronously clear all of the following to 0: readdata, irq, IRQMASK, EDGECAP, synchronizer stages, filtered and delayed values, and debounce counters.
REQ-019 Because the delayed and filtered values both reset to 0, deassertion SHALL NOT produce a spurious edge while inputs are low.
REQ-020 A reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-021 A shared package nios2_pio_pkg SHALL hold the register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and the edge-mode constants (EDGE_RISE, EDGE_FALL, EDGE_ANY).
REQ-022 One sub-module, nios2_pio_sync_debounce (a single-bit synchronizer plus debounce counter), SHALL be instantiated WIDTH times in a generate loop.

Verification
REQ-023 Scenario, reset and data path: reset, then drive in_port=8'hA5 and read address 0 -> readdata=32'h000000A5 within SYNC_STAGES+2 clocks; reset values are all 0.
REQ-024 Scenario, rising edge: EDGE_MODE=0, IRQMASK=8'h01, in_port[0] 0->1 -> EDGECAP=8'h01 and irq=1; then write 32'h1 to address 3 -> EDGECAP=0 and irq=0 one clock later.
REQ-025 Scenario, simultaneous clear and edge: write-1-clear of bit 3 in the same cycle bit 3's edge is detected -> EDGECAP[3] remains 1.
REQ-026 Scenario, debounce: DEBOUNCE_CYCLES=4, pulse in_port[1] high for 3 clocks -> no DATA change and no edge; hold high 6 clocks -> DATA[1]=1 and one edge captured.
REQ-027 Scenario, any-edge mode: EDGE_MODE=2, toggle bit 7 high then low with a clear between the two edges -> EDGECAP[7] is set on each edge; IRQMASK=0 keeps irq=0 throughout.
REQ-028 Scenario, reset mid-operation: assert reset_n with EDGECAP=8'hFF and IRQMASK=8'hFF -> irq=0, all registers 0 immediately, and no edge is captured after release with in_port=0.
